mem_access_unit: RTL and testbench

- MEM-stage consumer of the EX/MEM pipeline register. Decodes the memory ALU op and issues a request/acknowledge transaction to data memory.
- Returns aligned, extended load data toward the MEM/WB register.
- Raises a stall request to the stall controller while a memory transaction is outstanding.
- Non-memory ops pass straight through to write-back with zero added latency.

---
 rtl/mem_access_unit.sv | 242 ++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage data memory access unit. Decodes the memory op held
//               in EX/MEM, runs a registered request/acknowledge transaction
//               to data memory, formats load data (alignment + extension) and
//               stalls the pipeline while the transaction is outstanding.
//               Non-memory ops pass combinationally to MEM/WB.
// Ports       : clk, rst (async, active-high)
//               EX/MEM in : memALUop, memAddr, memReg, memWriteNum,
//                           memWriteReg, memWriteData, stallIn
//               MEM/WB out: wbWriteNum, wbWriteReg, wbWriteData
//               Stall out : stallReq
//               Memory bus: dmReq, dmWe, dmAddr, dmBe, dmWdata (registered),
//                           dmRdata, dmAck (in), memErr (timeout pulse)
// Options     : `define MEM_TIMEOUT_EN to abort a request after TIMEOUT
//               cycles without dmAck (memErr pulses on abort).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  memALUop,
    input  logic [31:0] memAddr,
    input  logic [31:0] memReg,
    input  logic [4:0]  memWriteNum,
    input  logic        memWriteReg,
    input  logic [31:0] memWriteData,
    input  logic        stallIn,
    output logic [4:0]  wbWriteNum,
    output logic        wbWriteReg,
    output logic [31:0] wbWriteData,
    output logic        stallReq,
    output logic        dmReq,
    output logic        dmWe,
    output logic [31:0] dmAddr,
    output logic [3:0]  dmBe,
    output logic [31:0] dmWdata,
    input  logic [31:0] dmRdata,
    input  logic        dmAck,
    output logic        memErr
);

    localparam logic [4:0] c_LB  = 5'h10;
    localparam logic [4:0] c_LH  = 5'h11;
    localparam logic [4:0] c_LBU = 5'h13;
    localparam logic [4:0] c_LHU = 5'h14;
    localparam logic [4:0] c_SB  = 5'h15;
    localparam logic [4:0] c_SH  = 5'h16;
    localparam logic [4:0] c_SW  = 5'h17;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_access_unit: TIMEOUT must be at least 1");
    end

    state_t      r_state;
    state_t      w_next;
    logic        r_dmReq;
    logic        r_dmWe;
    logic [31:0] r_dmAddr;
    logic [3:0]  r_dmBe;
    logic [31:0] r_dmWdata;
    logic [31:0] r_capData;

    // Memory ops occupy 5'h10..5'h17, i.e. the top two op bits are 2'b10.
    logic        w_isMem;
    logic        w_isStore;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_ldByte;
    logic [15:0] w_ldHalf;
    logic [31:0] w_ldData;
    logic        w_expire;

    assign w_isMem   = (memALUop[4:3] == 2'b10);
    assign w_isStore = (memALUop == c_SB) || (memALUop == c_SH) || (memALUop == c_SW);

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = memReg;
        case (memALUop)
            c_SB: begin
                w_be    = 4'b0001 << memAddr[1:0];
                w_wdata = {4{memReg[7:0]}};
            end
            c_SH: begin
                w_be    = memAddr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{memReg[15:0]}};
            end
            default: ;
        endcase
    end

    // EX/MEM keeps memAddr stable across the stall, so it can still steer
    // the lane select after the data has been captured.
    always_comb begin
        case (memAddr[1:0])
            2'd0:    w_ldByte = r_capData[7:0];
            2'd1:    w_ldByte = r_capData[15:8];
            2'd2:    w_ldByte = r_capData[23:16];
            default: w_ldByte = r_capData[31:24];
        endcase
        w_ldHalf = memAddr[1] ? r_capData[31:16] : r_capData[15:0];
        case (memALUop)
            c_LB:    w_ldData = {{24{w_ldByte[7]}}, w_ldByte};
            c_LBU:   w_ldData = {24'd0, w_ldByte};
            c_LH:    w_ldData = {{16{w_ldHalf[15]}}, w_ldHalf};
            c_LHU:   w_ldData = {16'd0, w_ldHalf};
            default: w_ldData = r_capData;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    logic          r_memErr;
    logic          r_timedOut;

    // Expiry only when no ack this cycle: a simultaneous ack wins.
    assign w_expire = (r_state == S_REQ) && !dmAck && (r_cnt == CW'(TIMEOUT - 1));
    assign memErr   = r_memErr;
`else
    assign w_expire = 1'b0;
    assign memErr   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        stallReq    = 1'b0;
        wbWriteNum  = memWriteNum;
        wbWriteReg  = memWriteReg;
        wbWriteData = memWriteData;
        case (r_state)
            S_IDLE: begin
                if (w_isMem) begin
                    stallReq   = 1'b1;
                    wbWriteReg = 1'b0;
                    w_next     = S_REQ;
                end
            end
            S_REQ: begin
                stallReq   = 1'b1;
                wbWriteReg = 1'b0;
                if (dmAck || w_expire) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (!w_isStore) begin
                    wbWriteData = w_ldData;
                end
`ifdef MEM_TIMEOUT_EN
                if (r_timedOut) begin
                    wbWriteReg = 1'b0;
                end
`endif
                if (!stallIn) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dmReq    <= 1'b0;
            r_dmWe     <= 1'b0;
            r_dmAddr   <= 32'd0;
            r_dmBe     <= 4'd0;
            r_dmWdata  <= 32'd0;
            r_capData  <= 32'd0;
`ifdef MEM_TIMEOUT_EN
            r_cnt      <= '0;
            r_memErr   <= 1'b0;
            r_timedOut <= 1'b0;
`endif
        end else begin
`ifdef MEM_TIMEOUT_EN
            r_memErr <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_isMem) begin
                        r_dmReq    <= 1'b1;
                        r_dmWe     <= w_isStore;
                        r_dmAddr   <= {memAddr[31:2], 2'b00};
                        r_dmBe     <= w_be;
                        r_dmWdata  <= w_wdata;
`ifdef MEM_TIMEOUT_EN
                        r_cnt      <= '0;
                        r_timedOut <= 1'b0;
`endif
                    end
                end
                S_REQ: begin
                    if (dmAck) begin
                        r_capData <= dmRdata;
                        r_dmReq   <= 1'b0;
                        r_dmWe    <= 1'b0;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (w_expire) begin
                        r_capData  <= 32'd0;
                        r_dmReq    <= 1'b0;
                        r_dmWe     <= 1'b0;
                        r_memErr   <= 1'b1;
                        r_timedOut <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign dmReq   = r_dmReq;
    assign dmWe    = r_dmWe;
    assign dmAddr  = r_dmAddr;
    assign dmBe    = r_dmBe;
    assign dmWdata = r_dmWdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit: directed vector
//               table, hand-written multi-cycle sequences (reset mid-request,
//               long ack wait or timeout) and randomized transactions checked
//               against a behavioural model of store/load formatting.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

`ifdef MEM_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 16;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  memALUop;
    logic [31:0] memAddr, memReg, memWriteData, dmRdata;
    logic [4:0]  memWriteNum;
    logic        memWriteReg, stallIn, dmAck;
    logic [4:0]  wbWriteNum;
    logic        wbWriteReg, stallReq, dmReq, dmWe, memErr;
    logic [31:0] wbWriteData, dmAddr, dmWdata;
    logic [3:0]  dmBe;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .memALUop(memALUop), .memAddr(memAddr), .memReg(memReg),
        .memWriteNum(memWriteNum), .memWriteReg(memWriteReg),
        .memWriteData(memWriteData), .stallIn(stallIn),
        .wbWriteNum(wbWriteNum), .wbWriteReg(wbWriteReg),
        .wbWriteData(wbWriteData), .stallReq(stallReq),
        .dmReq(dmReq), .dmWe(dmWe), .dmAddr(dmAddr), .dmBe(dmBe),
        .dmWdata(dmWdata), .dmRdata(dmRdata), .dmAck(dmAck), .memErr(memErr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (byte-lane arithmetic) ----------------
    function automatic bit is_store(input logic [4:0] op);
        return (op == 5'h15) || (op == 5'h16) || (op == 5'h17);
    endfunction

    function automatic logic [3:0] ref_be(input logic [4:0] op, input logic [1:0] a);
        if (op == 5'h15) return 4'(1 << a);
        if (op == 5'h16) return 4'(3 << (2 * a[1]));
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [4:0] op, input logic [31:0] r);
        logic [31:0] b, h;
        b = r & 32'hFF;
        h = r & 32'hFFFF;
        if (op == 5'h15) return b * 32'h0101_0101;
        if (op == 5'h16) return h * 32'h0001_0001;
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input logic [4:0] op, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (op)
            5'h10:   return (b >= 32'h80) ? b - 32'h100 : b;
            5'h13:   return b;
            5'h11:   return (h >= 32'h8000) ? h - 32'h1_0000 : h;
            5'h14:   return h;
            default: return w;
        endcase
    endfunction

    // ---------------- transaction drivers (entered/left at posedge+1) -------
    task automatic nonmem(input string nm, input logic [4:0] op, input logic [31:0] wd,
                          input logic [4:0] num, input logic wreg);
        memALUop = op; memWriteData = wd; memWriteNum = num; memWriteReg = wreg;
        dmAck = 1'b0; stallIn = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk({nm, ".wbData"}, wbWriteData, wd);
            chk({nm, ".wbNum"}, 32'(wbWriteNum), 32'(num));
            chk({nm, ".wbReg"}, 32'(wbWriteReg), 32'(wreg));
            chk({nm, ".stallReq"}, 32'(stallReq), 32'd0);
            chk({nm, ".dmReq"}, 32'(dmReq), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic mem_txn(input string nm, input logic [4:0] op, input logic [31:0] addr,
                           input logic [31:0] regv, input logic [31:0] rdata,
                           input logic [31:0] wd, input logic [4:0] num, input logic wreg,
                           input int ack_dly, input int stl, input logic [3:0] e_be,
                           input logic e_we, input logic [31:0] e_wdata,
                           input logic [31:0] e_wb);
        memALUop = op; memAddr = addr; memReg = regv; memWriteData = wd;
        memWriteNum = num; memWriteReg = wreg; dmAck = 1'b0; stallIn = 1'b0;
        @(negedge clk);
        chk({nm, ".idle.stallReq"}, 32'(stallReq), 32'd1);
        chk({nm, ".idle.wbReg"}, 32'(wbWriteReg), 32'd0);
        chk({nm, ".idle.dmReq"}, 32'(dmReq), 32'd0);
        for (int k = 0; k <= ack_dly; k++) begin
            @(posedge clk); #1;
            dmAck   = (k == ack_dly);
            dmRdata = (k == ack_dly) ? rdata : $urandom;
            stallIn = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk({nm, ".req.dmReq"}, 32'(dmReq), 32'd1);
            chk({nm, ".req.dmWe"}, 32'(dmWe), 32'(e_we));
            chk({nm, ".req.dmAddr"}, dmAddr, {addr[31:2], 2'b00});
            chk({nm, ".req.dmBe"}, 32'(dmBe), 32'(e_be));
            if (e_we) chk({nm, ".req.dmWdata"}, dmWdata, e_wdata);
            chk({nm, ".req.stallReq"}, 32'(stallReq), 32'd1);
            chk({nm, ".req.wbReg"}, 32'(wbWriteReg), 32'd0);
            chk({nm, ".req.memErr"}, 32'(memErr), 32'd0);
        end
        for (int s = 0; s <= stl; s++) begin
            @(posedge clk); #1;
            dmAck = 1'b1; dmRdata = $urandom;   // stray ack must be ignored
            stallIn = (s < stl);
            @(negedge clk);
            chk({nm, ".done.stallReq"}, 32'(stallReq), 32'd0);
            chk({nm, ".done.dmReq"}, 32'(dmReq), 32'd0);
            chk({nm, ".done.dmWe"}, 32'(dmWe), 32'd0);
            chk({nm, ".done.wbReg"}, 32'(wbWriteReg), 32'(wreg));
            chk({nm, ".done.wbNum"}, 32'(wbWriteNum), 32'(num));
            chk({nm, ".done.wbData"}, wbWriteData, e_wb);
        end
        @(posedge clk); #1;
        dmAck = 1'b0; stallIn = 1'b0; memALUop = 5'h00;
        @(negedge clk);
        chk({nm, ".back.stallReq"}, 32'(stallReq), 32'd0);
        chk({nm, ".back.dmReq"}, 32'(dmReq), 32'd0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] addr, regv, rdata, wd;
        int          ack_dly, stl;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata, wb;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{5'h10, 32'h103, 32'h0,         32'h80FF_0000, 32'h0,    0, 0, 4'hF, 1'b0, 32'h0,         32'hFFFF_FF80};
        tbl[1]  = '{5'h13, 32'h103, 32'h0,         32'h80FF_0000, 32'h0,    0, 0, 4'hF, 1'b0, 32'h0,         32'h0000_0080};
        tbl[2]  = '{5'h16, 32'h202, 32'hABCD_5678, 32'h0,         32'h5151, 2, 0, 4'hC, 1'b1, 32'h5678_5678, 32'h0000_5151};
        tbl[3]  = '{5'h12, 32'h300, 32'h0,         32'h1234_5678, 32'h0,    0, 2, 4'hF, 1'b0, 32'h0,         32'h1234_5678};
        tbl[4]  = '{5'h15, 32'h401, 32'hA5,        32'h0,         32'h77,   1, 1, 4'h2, 1'b1, 32'hA5A5_A5A5, 32'h0000_0077};
        tbl[5]  = '{5'h11, 32'h502, 32'h0,         32'h8001_7FFF, 32'h0,    0, 0, 4'hF, 1'b0, 32'h0,         32'hFFFF_8001};
        tbl[6]  = '{5'h14, 32'h500, 32'h0,         32'h8001_F00F, 32'h0,    1, 0, 4'hF, 1'b0, 32'h0,         32'h0000_F00F};
        tbl[7]  = '{5'h17, 32'h603, 32'h1122_3344, 32'h0,         32'h99,   0, 0, 4'hF, 1'b1, 32'h1122_3344, 32'h0000_0099};
        tbl[8]  = '{5'h10, 32'h100, 32'h0,         32'h0000_007F, 32'h0,    0, 0, 4'hF, 1'b0, 32'h0,         32'h0000_007F};
        tbl[9]  = '{5'h11, 32'h501, 32'h0,         32'h1234_ABCD, 32'h0,    0, 0, 4'hF, 1'b0, 32'h0,         32'hFFFF_ABCD};
        tbl[10] = '{5'h15, 32'h403, 32'h5A,        32'h0,         32'h1,    0, 0, 4'h8, 1'b1, 32'h5A5A_5A5A, 32'h0000_0001};

        rst = 1'b1; memALUop = 5'h00; memAddr = 32'h0; memReg = 32'h0;
        memWriteNum = 5'd0; memWriteReg = 1'b0; memWriteData = 32'h0;
        stallIn = 1'b0; dmRdata = 32'h0; dmAck = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst.dmReq", 32'(dmReq), 32'd0);
        chk("rst.dmWe", 32'(dmWe), 32'd0);
        chk("rst.dmAddr", dmAddr, 32'd0);
        chk("rst.dmBe", 32'(dmBe), 32'd0);
        chk("rst.dmWdata", dmWdata, 32'd0);
        chk("rst.memErr", 32'(memErr), 32'd0);
        chk("rst.stallReq", 32'(stallReq), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        nonmem("nonmem01", 5'h01, 32'h1234, 5'd5, 1'b1);

        foreach (tbl[i]) begin
            mem_txn($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].regv, tbl[i].rdata,
                    tbl[i].wd, 5'(i), 1'b1, tbl[i].ack_dly, tbl[i].stl, tbl[i].be, tbl[i].we,
                    tbl[i].wdata, tbl[i].wb);
        end

        // reset in the middle of a request
        memALUop = 5'h12; memAddr = 32'h700; memWriteNum = 5'd9; memWriteReg = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst.pre.dmReq", 32'(dmReq), 32'd1);
        #1;
        rst = 1'b1; memALUop = 5'h00; memWriteData = 32'h4242;
        #1;
        chk("midrst.async.dmReq", 32'(dmReq), 32'd0);
        chk("midrst.async.stallReq", 32'(stallReq), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; dmAck = 1'b1; dmRdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("midrst.late.dmReq", 32'(dmReq), 32'd0);
        chk("midrst.late.stallReq", 32'(stallReq), 32'd0);
        chk("midrst.late.wbData", wbWriteData, 32'h4242);
        @(posedge clk); #1;
        dmAck = 1'b0;
        mem_txn("postrst", 5'h12, 32'h704, 32'h0, 32'hCAFE_F00D, 32'h0, 5'd9, 1'b1,
                0, 0, 4'hF, 1'b0, 32'h0, 32'hCAFE_F00D);

`ifdef MEM_TIMEOUT_EN
        // no ack: abort after TO request cycles
        memALUop = 5'h12; memAddr = 32'h800; memWriteNum = 5'd3; memWriteReg = 1'b1;
        dmAck = 1'b0; stallIn = 1'b0;
        for (int k = 0; k < TO; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("tmo.req.dmReq", 32'(dmReq), 32'd1);
            chk("tmo.req.memErr", 32'(memErr), 32'd0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("tmo.done.dmReq", 32'(dmReq), 32'd0);
        chk("tmo.done.memErr", 32'(memErr), 32'd1);
        chk("tmo.done.wbReg", 32'(wbWriteReg), 32'd0);
        chk("tmo.done.stallReq", 32'(stallReq), 32'd0);
        chk("tmo.done.wbData", wbWriteData, 32'd0);
        @(posedge clk); #1;
        memALUop = 5'h00;
        @(negedge clk);
        chk("tmo.after.memErr", 32'(memErr), 32'd0);
        @(posedge clk); #1;
`else
        // without the timeout feature a long wait simply completes
        mem_txn("longwait", 5'h12, 32'h800, 32'h0, 32'h0BAD_F00D, 32'h0, 5'd3, 1'b1,
                20, 0, 4'hF, 1'b0, 32'h0, 32'h0BAD_F00D);
`endif

        // randomized transactions against the reference model
        for (int t = 0; t < 60; t++) begin
            logic [4:0]  op;
            logic [31:0] a, r, rd, wd;
            logic        wreg;
            logic [4:0]  num;
            int          v;
            a = $urandom; r = $urandom; rd = $urandom; wd = $urandom;
            wreg = 1'($urandom_range(0, 1)); num = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) begin
                v  = $urandom_range(0, 23);
                op = (v < 16) ? 5'(v) : 5'(v + 8);
                nonmem($sformatf("rnd%0d.nm", t), op, wd, num, wreg);
            end else begin
                op = 5'(5'h10 + $urandom_range(0, 7));
                mem_txn($sformatf("rnd%0d", t), op, a, r, rd, wd, num, wreg,
                        $urandom_range(0, 3), $urandom_range(0, 2),
                        ref_be(op, a[1:0]), is_store(op), ref_wdata(op, r),
                        is_store(op) ? wd : ref_load(op, a[1:0], rd));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
